// File: rtl/scan_pkg.sv
// Shared frame geometry and controller state encoding for the scan-chain master.
package scan_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_BITS  = 8;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    UPDATE,
    DRAIN,
    COMPLETE
  } state_t;

endpackage

// File: rtl/scan_rx_sync.sv
// Brings the returned chain clock and data into the clk domain and flags
// each rising edge of the returned clock.
module scan_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rtck,
  input  logic tdo,
  output logic tdo_s,
  output logic rtck_rise
);

  logic [1:0] rtck_sync;
  logic [1:0] tdo_sync;
  logic       rtck_d;

  // Two-flop synchronizers of equal depth keep tdo aligned with rtck.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rtck_sync <= '0;
      tdo_sync  <= '0;
      rtck_d    <= 1'b0;
    end else begin
      rtck_sync <= {rtck_sync[0], rtck};
      tdo_sync  <= {tdo_sync[0], tdo};
      rtck_d    <= rtck_sync[1];
    end
  end

  assign tdo_s     = tdo_sync[1];
  assign rtck_rise = rtck_sync[1] & ~rtck_d;

endmodule

// File: rtl/scan_chain_master.sv
// Scan-chain master: shifts {data, address} LSB first through the tap chain,
// issues one update pulse, then collects the returned frame into o_pins.
module scan_chain_master
  import scan_pkg::*;
#(
  parameter int NUM_DESIGNS = 10,
  parameter int DIV         = 4,
  parameter int TIMEOUT     = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] i_pins,
  input  logic                 rtck,
  input  logic                 tdo,
  output logic                 tck,
  output logic                 tms,
  output logic                 tdi,
  output logic [DATA_BITS-1:0] o_pins,
  output logic                 o_valid,
  output logic                 o_err
);

  localparam int TOTAL = FRAME_BITS + NUM_DESIGNS;
  localparam int CW    = $clog2(TOTAL + 2);
  localparam int DW    = $clog2(DIV);
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] TOTAL_C  = CW'(TOTAL);
  localparam logic [CW-1:0] RX_DONE  = CW'(TOTAL + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  state_t                  state;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [FRAME_BITS-1:0]   tx_shift;
  logic [FRAME_BITS-1:0]   rx_shift;
  logic [CW-1:0]           tx_count;
  logic [CW-1:0]           rx_count;
  logic [TW-1:0]           timeout_cnt;
  logic [DW-1:0]           div_cnt;
  logic                    tdo_s;
  logic                    rtck_rise;
  logic                    tck_edge;
  logic                    rx_active;

  scan_rx_sync u_rx_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .rtck      (rtck),
    .tdo       (tdo),
    .tdo_s     (tdo_s),
    .rtck_rise (rtck_rise)
  );

  assign tck_edge  = (div_cnt == DIV_LAST);
  assign rx_active = (state == SHIFT) || (state == UPDATE) || (state == DRAIN);

  // Transaction sequencer, tck divider, transmit shifter and receive capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      tx_count    <= '0;
      rx_count    <= '0;
      timeout_cnt <= '0;
      div_cnt     <= '0;
      tck         <= 1'b0;
      tms         <= 1'b0;
      tdi         <= 1'b0;
      o_pins      <= '0;
      o_valid     <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;

      // Only shift-phase edges carry frame bits; the update edge is just counted.
      if (rx_active && rtck_rise) begin
        if (rx_count < TOTAL_C) rx_shift <= {tdo_s, rx_shift[FRAME_BITS-1:1]};
        if (rx_count != RX_DONE) rx_count <= rx_count + 1'b1;
      end

      case (state)
        IDLE: state <= LOAD;

        LOAD: begin
          addr_q      <= addr;
          tx_shift    <= {i_pins, addr};
          tdi         <= addr[0];
          tms         <= 1'b1;
          tck         <= 1'b0;
          tx_count    <= '0;
          rx_count    <= '0;
          timeout_cnt <= '0;
          div_cnt     <= '0;
          state       <= SHIFT;
        end

        SHIFT: begin
          if (tck_edge) begin
            div_cnt <= '0;
            tck     <= ~tck;
            if (!tck) begin
              tx_count <= tx_count + 1'b1;
            end else if (tx_count == TOTAL_C) begin
              tms   <= 1'b0;
              tdi   <= 1'b0;
              state <= UPDATE;
            end else begin
              // Zero fill past the frame supplies the flush bits.
              tx_shift <= tx_shift >> 1;
              tdi      <= tx_shift[1];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        UPDATE: begin
          if (tck_edge) begin
            div_cnt <= '0;
            tck     <= ~tck;
            if (tck) state <= DRAIN;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        DRAIN: begin
          if (rx_count == RX_DONE) begin
            state <= COMPLETE;
          end else if (timeout_cnt == TO_LAST) begin
            o_err <= 1'b1;
            state <= LOAD;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end

        COMPLETE: begin
          if (rx_shift[ADDR_BITS-1:0] == addr_q) begin
            o_pins  <= rx_shift[FRAME_BITS-1:ADDR_BITS];
            o_valid <= 1'b1;
          end else begin
            o_err <= 1'b1;
          end
          state <= LOAD;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
